serial_sub_sequencer: RTL

//  Bit-serial controller that time-shares one 1-bit full-subtractor cell.

---
 rtl/serial_sub_sequencer_pkg.sv | 13 +
 rtl/serial_sub_sequencer_if.sv | 15 +
 rtl/serial_sub_sequencer_cell.sv | 12 +
 rtl/serial_sub_sequencer.sv | 73 +++++++
 4 files changed

// File: rtl/serial_sub_sequencer_pkg.sv
// sersub_pkg: shared FSM states, mode codes and counter-width helper for serial_sub_sequencer
package sersub_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [1:0] MODE_SUB  = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_TWOS = 2'b10;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/serial_sub_sequencer_if.sv
// serial_sub_sequencer_if: start/busy/done handshake and operand/result bus
//   master drives start, mode, a, b; slave drives busy, done, result, borrow_out, ovf
interface serial_sub_sequencer_if #(parameter int WIDTH = 8);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow_out;
    logic             ovf;
    modport master(output start, mode, a, b, input busy, done, result, borrow_out, ovf);
    modport slave(input start, mode, a, b, output busy, done, result, borrow_out, ovf);
endinterface

// File: rtl/serial_sub_sequencer_cell.sv
// sub_bit_cell: combinational 1-bit full subtractor
//   x, y, bin in; d = x - y - bin difference bit, bout borrow out
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub_sequencer.sv
// serial_sub_sequencer: LSB-first bit-serial A-B / ones(A) / twos(A) on one shared subtractor cell
//   clk, rst_n (async active-low); s: slave side of serial_sub_sequencer_if
//   start/mode/a/b sampled on accept in IDLE; busy during SHIFT; done one-cycle pulse;
//   result/borrow_out/ovf held from done until next accept.
//   Optional macro SERSUB_OVF_EN enables the signed overflow flag; otherwise ovf is tied 0.
module serial_sub_sequencer
    import sersub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_sub_sequencer_if.slave s
);
    localparam int CW = clog2(WIDTH);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] x, y, res;
    logic [1:0] op;
    logic bin, cd, cb, d, bout, ones, last, accept;
    sub_bit_cell u_cell (.x(x[0]), .y(y[0]), .bin(bin), .d(cd), .bout(cb));
    assign ones = op == MODE_ONES;
    assign d = ones ? ~x[0] : cd;
    assign bout = ones ? 1'b0 : cb;
    assign last = cnt == CW'(WIDTH - 1);
    assign accept = (state == IDLE) && s.start;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)  ? (s.start ? SHIFT : IDLE) :
                   (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end
    // x/y shift right so the bit under the cell is always bit 0; d enters result at the MSB
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
            res <= '0;
            op  <= MODE_SUB;
            bin <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            x   <= (s.mode == MODE_TWOS) ? '0 : s.a;
            y   <= (s.mode == MODE_TWOS) ? s.a : s.b;
            res <= '0;
            op  <= s.mode;
            bin <= 1'b0;
        end else if (state == SHIFT) begin
            cnt <= cnt + 1'b1;
            x   <= x >> 1;
            y   <= y >> 1;
            res <= {d, res[WIDTH-1:1]};
            bin <= bout;
        end
`ifdef SERSUB_OVF_EN
    logic ovf_q;
    // on the last bit x[0]/y[0] hold the original MSBs and d becomes the result MSB
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_q <= 1'b0;
        else if (accept) ovf_q <= 1'b0;
        else if (state == SHIFT && last) ovf_q <= !ones && (x[0] != y[0]) && (d != x[0]);
    assign s.ovf = ovf_q;
`else
    assign s.ovf = 1'b0;
`endif
    assign s.busy = state == SHIFT;
    assign s.done = state == DONE;
    assign s.result = res;
    assign s.borrow_out = bin;
endmodule
